// File: rtl/ins_exec_rv32i_env_trap_if.sv
// Core <-> environment/trap unit bus: instruction request, CSR write port, PC redirect and trap CSR views.
// Debug halt handshake signals exist only when ENV_TRAP_EBREAK_HALT_EN is defined.
interface ins_exec_rv32i_env_trap_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             op;
    logic [6:0]       ins_dec_op;
    logic [2:0]       ins_dec_funct3;
    logic [XLEN-1:0]  imm_ext_ext;
    logic [XLEN-1:0]  reg_pc_val;
    logic             csr_w_op;
    logic [11:0]      csr_w_addr;
    logic [XLEN-1:0]  csr_w_val;
    logic             reg_pc_w_op;
    logic [XLEN-1:0]  reg_pc_w_val;
    logic             done;
    logic             busy;
    logic [XLEN-1:0]  mtvec;
    logic [XLEN-1:0]  mepc;
    logic [XLEN-1:0]  mcause;
    logic [CNT_W-1:0] trap_cnt;
`ifdef ENV_TRAP_EBREAK_HALT_EN
    logic             dbg_halted;
    logic             dbg_resume;
`endif

    modport master (
`ifdef ENV_TRAP_EBREAK_HALT_EN
        input  dbg_halted,
        output dbg_resume,
`endif
        output op, ins_dec_op, ins_dec_funct3, imm_ext_ext, reg_pc_val,
        output csr_w_op, csr_w_addr, csr_w_val,
        input  reg_pc_w_op, reg_pc_w_val, done, busy,
        input  mtvec, mepc, mcause, trap_cnt
    );

    modport slave (
`ifdef ENV_TRAP_EBREAK_HALT_EN
        output dbg_halted,
        input  dbg_resume,
`endif
        input  op, ins_dec_op, ins_dec_funct3, imm_ext_ext, reg_pc_val,
        input  csr_w_op, csr_w_addr, csr_w_val,
        output reg_pc_w_op, reg_pc_w_val, done, busy,
        output mtvec, mepc, mcause, trap_cnt
    );
endinterface

// File: rtl/ins_exec_rv32i_env_trap.sv
// Machine-mode environment/trap unit: ECALL/EBREAK/illegal trap to mtvec, MRET back to mepc, trap counting.
// Define ENV_TRAP_EBREAK_HALT_EN to send EBREAK into a debug halt (dbg_halted/dbg_resume) instead of trapping.
module ins_exec_rv32i_env_trap #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter int unsigned     CNT_W     = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    ins_exec_rv32i_env_trap_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        JUMP,
`ifdef ENV_TRAP_EBREAK_HALT_EN
        HALT,
`endif
        RET
    } state_t;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [3:0]  CAUSE_ECALL   = 4'd11;
    localparam logic [3:0]  CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0]  CAUSE_ILLEGAL = 4'd2;

    state_t            state, state_nxt;
    logic              pc_w_op_q, pc_w_op_nxt;
    logic [XLEN-1:0]   pc_w_val_q, pc_w_val_nxt;
    logic              done_q, done_nxt;
    logic [XLEN-1:0]   mtvec_q, mtvec_nxt;
    logic [XLEN-1:0]   mepc_q, mepc_nxt;
    logic [XLEN-1:0]   mcause_q, mcause_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [3:0]        cause_q, cause_nxt;
`ifdef ENV_TRAP_EBREAK_HALT_EN
    logic [XLEN-1:0]   halt_pc_q, halt_pc_nxt;
`endif

    logic hit, is_ecall, is_ebreak, is_mret;

    // done_q is still high in the cycle after a redirect, so a core that has not yet dropped op cannot retrigger
    assign hit       = bus.op && (bus.ins_dec_op == OPC_SYSTEM) && (bus.ins_dec_funct3 == 3'h0) && !done_q;
    assign is_ecall  = (bus.imm_ext_ext == '0);
    assign is_ebreak = (bus.imm_ext_ext == XLEN'(1));
    assign is_mret   = (bus.imm_ext_ext == XLEN'(12'h302));

    always_comb begin
        state_nxt    = state;
        pc_w_op_nxt  = 1'b0;
        pc_w_val_nxt = pc_w_val_q;
        done_nxt     = 1'b0;
        mtvec_nxt    = mtvec_q;
        mepc_nxt     = mepc_q;
        mcause_nxt   = mcause_q;
        cnt_nxt      = cnt_q;
        cause_nxt    = cause_q;
`ifdef ENV_TRAP_EBREAK_HALT_EN
        halt_pc_nxt  = halt_pc_q;
`endif

        if (bus.csr_w_op) begin
            case (bus.csr_w_addr)
                CSR_MTVEC:  mtvec_nxt  = {bus.csr_w_val[XLEN-1:2], 2'b00};
                CSR_MEPC:   mepc_nxt   = {bus.csr_w_val[XLEN-1:2], 2'b00};
                CSR_MCAUSE: mcause_nxt = bus.csr_w_val;
                default: ;
            endcase
        end

        // Trap bookkeeping below overrides any same-cycle CSR write to mepc/mcause
        unique case (state)
            IDLE: begin
                if (hit) begin
                    if (is_mret) begin
                        state_nxt = RET;
`ifdef ENV_TRAP_EBREAK_HALT_EN
                    end else if (is_ebreak) begin
                        state_nxt   = HALT;
                        halt_pc_nxt = bus.reg_pc_val;
`endif
                    end else begin
                        state_nxt = SAVE;
                        cause_nxt = is_ecall ? CAUSE_ECALL : (is_ebreak ? CAUSE_EBREAK : CAUSE_ILLEGAL);
                    end
                end
            end
            SAVE: begin
                mepc_nxt   = {bus.reg_pc_val[XLEN-1:2], 2'b00};
                mcause_nxt = XLEN'(cause_q);
                cnt_nxt    = cnt_q + CNT_W'(1);
                state_nxt  = JUMP;
            end
            JUMP: begin
                pc_w_op_nxt  = 1'b1;
                pc_w_val_nxt = mtvec_q;
                done_nxt     = 1'b1;
                state_nxt    = IDLE;
            end
            RET: begin
                pc_w_op_nxt  = 1'b1;
                pc_w_val_nxt = mepc_q;
                done_nxt     = 1'b1;
                state_nxt    = IDLE;
            end
`ifdef ENV_TRAP_EBREAK_HALT_EN
            HALT: begin
                if (bus.dbg_resume) begin
                    pc_w_op_nxt  = 1'b1;
                    pc_w_val_nxt = halt_pc_q + XLEN'(4);
                    done_nxt     = 1'b1;
                    state_nxt    = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_w_op_q  <= 1'b0;
            pc_w_val_q <= '0;
            done_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RST[XLEN-1:2], 2'b00};
            mepc_q     <= '0;
            mcause_q   <= '0;
            cnt_q      <= '0;
            cause_q    <= '0;
`ifdef ENV_TRAP_EBREAK_HALT_EN
            halt_pc_q  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            pc_w_op_q  <= pc_w_op_nxt;
            pc_w_val_q <= pc_w_val_nxt;
            done_q     <= done_nxt;
            mtvec_q    <= mtvec_nxt;
            mepc_q     <= mepc_nxt;
            mcause_q   <= mcause_nxt;
            cnt_q      <= cnt_nxt;
            cause_q    <= cause_nxt;
`ifdef ENV_TRAP_EBREAK_HALT_EN
            halt_pc_q  <= halt_pc_nxt;
`endif
        end
    end

    assign bus.reg_pc_w_op  = pc_w_op_q;
    assign bus.reg_pc_w_val = pc_w_val_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state != IDLE);
    assign bus.mtvec        = mtvec_q;
    assign bus.mepc         = mepc_q;
    assign bus.mcause       = mcause_q;
    assign bus.trap_cnt     = cnt_q;
`ifdef ENV_TRAP_EBREAK_HALT_EN
    assign bus.dbg_halted   = (state == HALT);
`endif

endmodule

// File: tb/tb_ins_exec_rv32i_env_trap.sv
// Bench for ins_exec_rv32i_env_trap: directed literal scenarios plus randomized traffic against a timeline model.
// Honours ENV_TRAP_EBREAK_HALT_EN the same way as the design.
module tb_ins_exec_rv32i_env_trap;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = 2;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam int K_TRAP = 0;
    localparam int K_MRET = 1;
    localparam int K_HALT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ins_exec_rv32i_env_trap_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    ins_exec_rv32i_env_trap #(
        .XLEN(XLEN),
        .MTVEC_RST(MTVEC_RST),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Reference model: a started instruction is a timeline relative to its start edge.
    // Trap: +1 edge saves mepc/mcause/count, +2 edge redirects to mtvec. MRET: +1 edge redirects to mepc.
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_pcval, m_cause, m_halt_pc;
    int unsigned m_cnt;
    bit          m_pcw, m_done, m_active;
    int          m_kind, m_age;

    task automatic m_reset();
        m_mtvec  = MTVEC_RST & ~32'h3;
        m_mepc   = '0;
        m_mcause = '0;
        m_pcval  = '0;
        m_cnt    = 0;
        m_pcw    = 1'b0;
        m_done   = 1'b0;
        m_active = 1'b0;
        m_kind   = K_TRAP;
        m_age    = 0;
        m_cause  = '0;
        m_halt_pc = '0;
    endtask

    task automatic m_redirect(input logic [31:0] target);
        m_pcw    = 1'b1;
        m_done   = 1'b1;
        m_pcval  = target;
        m_active = 1'b0;
    endtask

    task automatic m_step();
        bit          prev_done = m_done;
        bit          saved = 1'b0;
        logic [31:0] old_mtvec = m_mtvec;
        logic [31:0] old_mepc  = m_mepc;
        m_pcw  = 1'b0;
        m_done = 1'b0;
        if (m_active) begin
            m_age++;
            if (m_kind == K_TRAP && m_age == 1) begin
                m_mepc   = bus.reg_pc_val & ~32'h3;
                m_mcause = m_cause;
                m_cnt    = (m_cnt + 1) % (1 << CNT_W);
                saved    = 1'b1;
            end else if (m_kind == K_TRAP && m_age == 2) begin
                m_redirect(old_mtvec);
            end else if (m_kind == K_MRET) begin
                m_redirect(old_mepc);
`ifdef ENV_TRAP_EBREAK_HALT_EN
            end else if (m_kind == K_HALT && bus.dbg_resume) begin
                m_redirect(m_halt_pc + 32'd4);
`endif
            end
        end else if (bus.op && bus.ins_dec_op == 7'h73 && bus.ins_dec_funct3 == 3'h0 && !prev_done) begin
            m_active = 1'b1;
            m_age    = 0;
            m_kind   = K_TRAP;
            if (bus.imm_ext_ext == 32'h302) m_kind = K_MRET;
            else if (bus.imm_ext_ext == 32'h0) m_cause = 32'd11;
            else if (bus.imm_ext_ext == 32'h1) begin
`ifdef ENV_TRAP_EBREAK_HALT_EN
                m_kind    = K_HALT;
                m_halt_pc = bus.reg_pc_val;
`else
                m_cause   = 32'd3;
`endif
            end else m_cause = 32'd2;
        end
        if (bus.csr_w_op) begin
            case (bus.csr_w_addr)
                12'h305: m_mtvec = bus.csr_w_val & ~32'h3;
                12'h341: if (!saved) m_mepc = bus.csr_w_val & ~32'h3;
                12'h342: if (!saved) m_mcause = bus.csr_w_val;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else m_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc_w_op",  32'(bus.reg_pc_w_op), 32'(m_pcw));
            chk("pc_w_val", bus.reg_pc_w_val,     m_pcval);
            chk("done",     32'(bus.done),        32'(m_done));
            chk("busy",     32'(bus.busy),        32'(m_active));
            chk("mtvec",    bus.mtvec,            m_mtvec);
            chk("mepc",     bus.mepc,             m_mepc);
            chk("mcause",   bus.mcause,           m_mcause);
            chk("trap_cnt", 32'(bus.trap_cnt),    32'(m_cnt));
`ifdef ENV_TRAP_EBREAK_HALT_EN
            chk("dbg_halted", 32'(bus.dbg_halted), 32'(m_active && m_kind == K_HALT));
`endif
        end
    end

    task automatic idle_inputs();
        bus.op             = 1'b0;
        bus.ins_dec_op     = 7'h73;
        bus.ins_dec_funct3 = 3'h0;
        bus.imm_ext_ext    = '0;
        bus.reg_pc_val     = '0;
        bus.csr_w_op       = 1'b0;
        bus.csr_w_addr     = '0;
        bus.csr_w_val      = '0;
`ifdef ENV_TRAP_EBREAK_HALT_EN
        bus.dbg_resume     = 1'b0;
`endif
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] val);
        @(negedge clk);
        bus.csr_w_op   = 1'b1;
        bus.csr_w_addr = addr;
        bus.csr_w_val  = val;
        @(negedge clk);
        bus.csr_w_op   = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] imm, input logic [31:0] pc);
        @(negedge clk);
        bus.op             = 1'b1;
        bus.ins_dec_op     = 7'h73;
        bus.ins_dec_funct3 = 3'h0;
        bus.imm_ext_ext    = imm;
        bus.reg_pc_val     = pc;
    endtask

    logic [31:0] wrap_exp [4] = '{32'd1, 32'd2, 32'd3, 32'd0};
    logic [11:0] csr_addrs [4] = '{12'h305, 12'h341, 12'h342, 12'h300};
    logic [31:0] imm_pick [5] = '{32'h0, 32'h1, 32'h302, 32'h105, 32'h0};

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        chk("rst_mtvec", bus.mtvec, 32'h1000);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_cnt", 32'(bus.trap_cnt), 32'h0);

        // ECALL at 0x100 with mtvec programmed to 0x803 (low bits dropped)
        csr_write(12'h305, 32'h803);
        chk("mtvec_wr", bus.mtvec, 32'h800);
        start_op(32'h0, 32'h100);
        repeat (3) @(negedge clk);
        chk("ecall_pcw", 32'(bus.reg_pc_w_op), 32'h1);
        chk("ecall_val", bus.reg_pc_w_val, 32'h800);
        chk("ecall_done", 32'(bus.done), 32'h1);
        chk("ecall_mepc", bus.mepc, 32'h100);
        chk("ecall_mcause", bus.mcause, 32'd11);
        chk("ecall_cnt", 32'(bus.trap_cnt), 32'd1);
        @(negedge clk);
        chk("no_retrigger", 32'(bus.busy), 32'h0);
        bus.op = 1'b0;

        // MRET back to a software-written mepc
        csr_write(12'h341, 32'h104);
        start_op(32'h302, 32'h500);
        repeat (2) @(negedge clk);
        chk("mret_pcw", 32'(bus.reg_pc_w_op), 32'h1);
        chk("mret_val", bus.reg_pc_w_val, 32'h104);
        chk("mret_cnt", 32'(bus.trap_cnt), 32'd1);
        bus.op = 1'b0;

        // Illegal funct12
        start_op(32'h105, 32'h20);
        repeat (3) @(negedge clk);
        chk("ill_val", bus.reg_pc_w_val, 32'h800);
        chk("ill_mcause", bus.mcause, 32'd2);
        chk("ill_mepc", bus.mepc, 32'h20);
        bus.op = 1'b0;

        // Reset while the ECALL sits in its save cycle
        start_op(32'h0, 32'h300);
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_mepc", bus.mepc, 32'h0);
        chk("abort_mtvec", bus.mtvec, 32'h1000);
        chk("abort_pcw", 32'(bus.reg_pc_w_op), 32'h0);
        bus.op = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Counter wraps at CNT_W=2
        for (int i = 0; i < 4; i++) begin
            start_op(32'h0, 32'h200 + 32'(i * 4));
            repeat (3) @(negedge clk);
            chk("wrap_cnt", 32'(bus.trap_cnt), wrap_exp[i]);
            bus.op = 1'b0;
        end

`ifdef ENV_TRAP_EBREAK_HALT_EN
        start_op(32'h1, 32'h40);
        repeat (3) @(negedge clk);
        chk("halt_flag", 32'(bus.dbg_halted), 32'h1);
        chk("halt_pcw", 32'(bus.reg_pc_w_op), 32'h0);
        bus.op = 1'b0;
        @(negedge clk);
        bus.dbg_resume = 1'b1;
        @(negedge clk);
        bus.dbg_resume = 1'b0;
        chk("resume_val", bus.reg_pc_w_val, 32'h44);
        chk("resume_pcw", 32'(bus.reg_pc_w_op), 32'h1);
        chk("resume_mcause", bus.mcause, 32'd11);
        chk("resume_flag", 32'(bus.dbg_halted), 32'h0);
`endif

        // Randomized traffic: inputs change every cycle, CSR writes collide with traps freely
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.op             = ($urandom_range(0, 9) < 7);
            bus.ins_dec_op     = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h73;
            bus.ins_dec_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'h0;
            bus.imm_ext_ext    = ($urandom_range(0, 5) == 0) ? $urandom : imm_pick[$urandom_range(0, 4)];
            bus.reg_pc_val     = $urandom;
            bus.csr_w_op       = ($urandom_range(0, 4) == 0);
            bus.csr_w_addr     = csr_addrs[$urandom_range(0, 3)];
            bus.csr_w_val      = $urandom;
`ifdef ENV_TRAP_EBREAK_HALT_EN
            bus.dbg_resume     = ($urandom_range(0, 3) == 0);
`endif
        end
        idle_inputs();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
